// File: rtl/rv_frontend_if_id.sv
`default_nettype none
// ============================================================================
// Module      : rv_frontend_if_id
// Description : RV32I/RV64I pipeline front end. It holds the PC and fetches
//               through a valid-qualified instruction-memory port. It also
//               contains the IF/ID register, the register file with optional
//               write-back bypass, immediate generation, main control decode
//               and the ID/EX register. It handles redirect flush, load-use
//               stall and fetch-wait bubbles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN       datapath / PC width (32 or 64)
//   RESET_PC   PC loaded on reset
//   WB_BYPASS  1: a same-cycle WB write is visible to decode reads
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   imem_addr/rdata/valid    instruction fetch port (addr = PC register)
//   pc_sel, pc_target        redirect from EX (taken branch / jump)
//   wb_regwrite/rd/wd        register-file write port from WB
//   id_ex_*                  decoded instruction presented to EX
//   stall                    load-use stall (combinational)
// ============================================================================
module rv_frontend_if_id #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter bit              WB_BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   input  logic            pc_sel,
   input  logic [XLEN-1:0] pc_target,
   input  logic            wb_regwrite,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_wd,
   output logic [XLEN-1:0] id_ex_a,
   output logic [XLEN-1:0] id_ex_b,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [4:0]      id_ex_rs1,
   output logic [4:0]      id_ex_rs2,
   output logic [4:0]      id_ex_rd,
   output logic [2:0]      id_ex_funct3,
   output logic            id_ex_funct7b5,
   output logic            id_ex_regwrite,
   output logic            id_ex_memwrite,
   output logic            id_ex_memread,
   output logic            id_ex_branch,
   output logic            id_ex_jump,
   output logic            id_ex_alusrc,
   output logic [1:0]      id_ex_wbsel,
   output logic            id_ex_valid,
   output logic            stall
);

   localparam logic [6:0]      c_op_r      = 7'b0110011;
   localparam logic [6:0]      c_op_imm    = 7'b0010011;
   localparam logic [6:0]      c_op_load   = 7'b0000011;
   localparam logic [6:0]      c_op_store  = 7'b0100011;
   localparam logic [6:0]      c_op_branch = 7'b1100011;
   localparam logic [6:0]      c_op_jal    = 7'b1101111;
   localparam logic [6:0]      c_op_jalr   = 7'b1100111;
   localparam logic [6:0]      c_op_lui    = 7'b0110111;
   localparam logic [6:0]      c_op_auipc  = 7'b0010111;
   localparam logic [31:0]     c_nop       = 32'h0000_0013;
   localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);
   localparam logic [1:0]      c_wb_alu    = 2'd0;
   localparam logic [1:0]      c_wb_mem    = 2'd1;
   localparam logic [1:0]      c_wb_pc4    = 2'd2;

   // ------------------------------------------------------------------------
   // Fetch state and IF/ID register
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] r_pc;
   logic            r_ifid_valid;
   logic [31:0]     r_ifid_instr;
   logic [XLEN-1:0] r_ifid_pc;

   assign imem_addr = r_pc;

   // Redirect wins over everything. A stall freezes PC and IF/ID so that the
   // dependent instruction is decoded again once the load has moved on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= c_nop;
         r_ifid_pc    <= '0;
      end else if (pc_sel) begin
         r_pc         <= pc_target;
         r_ifid_valid <= 1'b0;
      end else if (!stall) begin
         if (imem_valid) begin
            r_ifid_instr <= imem_rdata;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + c_pc_step;
         end else begin
            r_ifid_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------------
   logic [6:0] w_opcode;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_rd;

   assign w_opcode = r_ifid_instr[6:0];
   assign w_rs1    = r_ifid_instr[19:15];
   assign w_rs2    = r_ifid_instr[24:20];
   assign w_rd     = r_ifid_instr[11:7];

   // ------------------------------------------------------------------------
   // Register file (contents are deliberately not reset)
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] r_rf [32];
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;

   always_ff @(posedge clk) begin
      if (wb_regwrite && (wb_rd != 5'd0)) begin
         r_rf[wb_rd] <= wb_wd;
      end
   end

   generate
      if (WB_BYPASS) begin : g_bypass
         logic w_hit1;
         logic w_hit2;
         assign w_hit1    = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == w_rs1);
         assign w_hit2    = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == w_rs2);
         assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_hit1 ? wb_wd : r_rf[w_rs1]);
         assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_hit2 ? wb_wd : r_rf[w_rs2]);
      end else begin : g_no_bypass
         assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
         assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Immediate generation and main control decode
   // ------------------------------------------------------------------------
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic            w_ctl_regwrite;
   logic            w_ctl_memwrite;
   logic            w_ctl_memread;
   logic            w_ctl_branch;
   logic            w_ctl_jump;
   logic            w_ctl_alusrc;
   logic [1:0]      w_ctl_wbsel;

   always_comb begin
      w_imm32        = '0;
      w_ctl_regwrite = 1'b0;
      w_ctl_memwrite = 1'b0;
      w_ctl_memread  = 1'b0;
      w_ctl_branch   = 1'b0;
      w_ctl_jump     = 1'b0;
      w_ctl_alusrc   = 1'b0;
      w_ctl_wbsel    = c_wb_alu;
      case (w_opcode)
         c_op_r: begin
            w_ctl_regwrite = 1'b1;
         end
         c_op_imm: begin
            w_imm32        = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            w_ctl_regwrite = 1'b1;
            w_ctl_alusrc   = 1'b1;
         end
         c_op_load: begin
            w_imm32        = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            w_ctl_regwrite = 1'b1;
            w_ctl_memread  = 1'b1;
            w_ctl_alusrc   = 1'b1;
            w_ctl_wbsel    = c_wb_mem;
         end
         c_op_store: begin
            w_imm32        = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25],
                              r_ifid_instr[11:7]};
            w_ctl_memwrite = 1'b1;
            w_ctl_alusrc   = 1'b1;
         end
         c_op_branch: begin
            w_imm32        = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                              r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
            w_ctl_branch   = 1'b1;
         end
         c_op_jal: begin
            w_imm32        = {{11{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[19:12],
                              r_ifid_instr[20], r_ifid_instr[30:21], 1'b0};
            w_ctl_jump     = 1'b1;
            w_ctl_regwrite = 1'b1;
            w_ctl_wbsel    = c_wb_pc4;
         end
         c_op_jalr: begin
            w_imm32        = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            w_ctl_jump     = 1'b1;
            w_ctl_regwrite = 1'b1;
            w_ctl_alusrc   = 1'b1;
            w_ctl_wbsel    = c_wb_pc4;
         end
         c_op_lui, c_op_auipc: begin
            w_imm32        = {r_ifid_instr[31:12], 12'h000};
            w_ctl_regwrite = 1'b1;
            w_ctl_alusrc   = 1'b1;
         end
         default: begin
            // Unknown opcode: no side effects, but it still occupies a slot.
         end
      endcase
   end

   // Every format is built as a 32-bit value; RV64 sign-extends it from there.
   assign w_imm = XLEN'($signed(w_imm32));

   // ------------------------------------------------------------------------
   // Hazard detection and ID/EX register
   // ------------------------------------------------------------------------
   logic w_issue;

   assign stall = id_ex_valid & id_ex_memread & (id_ex_rd != 5'd0) & r_ifid_valid &
                  ((id_ex_rd == w_rs1) | (id_ex_rd == w_rs2));

   // Anything that does not issue becomes an all-zero bubble.
   assign w_issue = r_ifid_valid & ~pc_sel & ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_a        <= '0;
         id_ex_b        <= '0;
         id_ex_imm      <= '0;
         id_ex_pc       <= '0;
         id_ex_rs1      <= '0;
         id_ex_rs2      <= '0;
         id_ex_rd       <= '0;
         id_ex_funct3   <= '0;
         id_ex_funct7b5 <= 1'b0;
         id_ex_regwrite <= 1'b0;
         id_ex_memwrite <= 1'b0;
         id_ex_memread  <= 1'b0;
         id_ex_branch   <= 1'b0;
         id_ex_jump     <= 1'b0;
         id_ex_alusrc   <= 1'b0;
         id_ex_wbsel    <= '0;
         id_ex_valid    <= 1'b0;
      end else begin
         id_ex_a        <= w_issue ? w_rs1_val : '0;
         id_ex_b        <= w_issue ? w_rs2_val : '0;
         id_ex_imm      <= w_issue ? w_imm : '0;
         id_ex_pc       <= w_issue ? r_ifid_pc : '0;
         id_ex_rs1      <= w_issue ? w_rs1 : '0;
         id_ex_rs2      <= w_issue ? w_rs2 : '0;
         id_ex_rd       <= w_issue ? w_rd : '0;
         id_ex_funct3   <= w_issue ? r_ifid_instr[14:12] : '0;
         id_ex_funct7b5 <= w_issue & r_ifid_instr[30];
         id_ex_regwrite <= w_issue & w_ctl_regwrite;
         id_ex_memwrite <= w_issue & w_ctl_memwrite;
         id_ex_memread  <= w_issue & w_ctl_memread;
         id_ex_branch   <= w_issue & w_ctl_branch;
         id_ex_jump     <= w_issue & w_ctl_jump;
         id_ex_alusrc   <= w_issue & w_ctl_alusrc;
         id_ex_wbsel    <= w_issue ? w_ctl_wbsel : '0;
         id_ex_valid    <= w_issue;
      end
   end

endmodule
`default_nettype wire
